// File: rtl/uart_io_pkg.sv
// Shared constants and types for the UART memory-mapped IO controller.
// Optional loopback build: define UART_IO_LOOPBACK_EN.
package uart_io_pkg;

    localparam logic [3:0] IO_TX_RDY  = 4'h0;
    localparam logic [3:0] IO_RX_VLD  = 4'h4;
    localparam logic [3:0] IO_STATUS  = 4'h8;
    localparam logic [3:0] IO_RX_DATA = 4'hC;

    localparam int ST_TX_OVF = 0;
    localparam int ST_RX_OVR = 1;
    localparam int ST_TX_CNT = 2;
    localparam int ST_RX_CNT = 8;

    typedef enum logic {
        TX_IDLE,
        TX_SEND
    } tx_state_t;

    function automatic logic [31:0] status_word(
        input logic [7:0] rx_cnt,
        input logic [5:0] tx_cnt,
        input logic       rx_ovr,
        input logic       tx_ovf
    );
        logic [31:0] w;
        w = '0;
        w[ST_RX_CNT +: 8] = rx_cnt;
        w[ST_TX_CNT +: 6] = tx_cnt;
        w[ST_RX_OVR]      = rx_ovr;
        w[ST_TX_OVF]      = tx_ovf;
        return w;
    endfunction

endpackage

// File: rtl/uart_io_fifo.sv
// Synchronous FIFO with occupancy count and combinational head.
// Callers never push into a full FIFO unless popping in the same cycle.
module uart_io_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == (AW + 1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/uart_io_ctrl.sv
// CPU IO window to UART bridge with TX/RX FIFOs and sticky error flags.
// Define UART_IO_LOOPBACK_EN to route the TX drain into the RX FIFO.
module uart_io_ctrl
    import uart_io_pkg::*;
#(
    parameter int TX_DEPTH = 8,
    parameter int RX_DEPTH = 8
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        IoWrEn,
    input  logic [7:0]  IoWrData,
    input  logic        IoRdEn,
    input  logic [3:0]  IoAddr,
    output logic [31:0] IoRdData,
    output logic [7:0]  TxDataIn,
    output logic        TxDataInValid,
    input  logic        TxDataInReady,
    input  logic [7:0]  RxDataOut,
    input  logic        RxDataOutValid,
    output logic        RxDataOutReady
);

    localparam int TCW = $clog2(TX_DEPTH) + 1;
    localparam int RCW = $clog2(RX_DEPTH) + 1;

    tx_state_t        tx_state;
    tx_state_t        tx_state_n;
    logic [7:0]       tx_data;
    logic             tx_push;
    logic             tx_pop;
    logic             tx_done;
    logic [7:0]       tx_head;
    logic             tx_full;
    logic             tx_empty;
    logic [TCW-1:0]   tx_count;
    logic             tx_ovf;
    logic             tx_ovf_set;

    logic             rx_push;
    logic             rx_pop;
    logic [7:0]       rx_din;
    logic [7:0]       rx_head;
    logic             rx_full;
    logic             rx_empty;
    logic [RCW-1:0]   rx_count;
    logic             rx_ovr;
    logic             rx_ovr_set;

    logic             rd_status;

    uart_io_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk   (Clock),
        .rst_n (Reset_n),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (IoWrData),
        .head  (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    uart_io_fifo #(.DEPTH(RX_DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk   (Clock),
        .rst_n (Reset_n),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (rx_din),
        .head  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

`ifdef UART_IO_LOOPBACK_EN
    logic unused_uart;
    assign unused_uart    = ^{RxDataOut, RxDataOutValid, TxDataInReady};
    assign tx_done        = !rx_full;
    assign rx_push        = (tx_state == TX_SEND) && !rx_full;
    assign rx_din         = tx_data;
    assign rx_ovr_set     = 1'b0;
    assign RxDataOutReady = 1'b0;
    assign TxDataInValid  = 1'b0;
`else
    assign tx_done        = TxDataInReady;
    assign rx_push        = RxDataOutValid && !rx_full;
    assign rx_din         = RxDataOut;
    assign rx_ovr_set     = RxDataOutValid && rx_full;
    assign RxDataOutReady = !rx_full;
    assign TxDataInValid  = (tx_state == TX_SEND);
`endif

    // A pop by the drain FSM frees a slot for a same-cycle store.
    assign tx_push    = IoWrEn && (!tx_full || tx_pop);
    assign tx_ovf_set = IoWrEn && tx_full && !tx_pop;
    assign rd_status  = IoRdEn && (IoAddr == IO_STATUS);
    assign rx_pop     = IoRdEn && (IoAddr == IO_RX_DATA) && !rx_empty;
    assign TxDataIn   = tx_data;

    always_comb begin
        tx_state_n = tx_state;
        tx_pop     = 1'b0;
        unique case (tx_state)
            TX_IDLE: begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_state_n = TX_SEND;
                end
            end
            TX_SEND: begin
                if (tx_done) begin
                    if (!tx_empty) tx_pop = 1'b1;
                    else           tx_state_n = TX_IDLE;
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            tx_state <= TX_IDLE;
            tx_data  <= '0;
        end else begin
            tx_state <= tx_state_n;
            if (tx_pop) tx_data <= tx_head;
        end
    end

    // Setting a flag takes priority over clearing it by a status read.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            tx_ovf <= 1'b0;
            rx_ovr <= 1'b0;
        end else begin
            tx_ovf <= tx_ovf_set || (tx_ovf && !rd_status);
            rx_ovr <= rx_ovr_set || (rx_ovr && !rd_status);
        end
    end

    always_comb begin
        IoRdData = '0;
        unique case (1'b1)
            (IoAddr == IO_TX_RDY):  IoRdData = {31'b0, !tx_full};
            (IoAddr == IO_RX_VLD):  IoRdData = {31'b0, !rx_empty};
            (IoAddr == IO_STATUS):  IoRdData = status_word(8'(rx_count),
                                                           6'(tx_count),
                                                           rx_ovr, tx_ovf);
            (IoAddr == IO_RX_DATA): IoRdData = rx_empty ? 32'b0
                                                        : {24'b0, rx_head};
            default:                IoRdData = '0;
        endcase
    end

endmodule

// File: tb/tb_uart_io_ctrl.sv
// Self-checking bench for uart_io_ctrl: directed steps plus randomized
// traffic against a queue-based model of the IO window.
module tb_uart_io_ctrl;

    localparam int TXD = 8;
    localparam int RXD = 8;

    logic        Clock = 1'b0;
    logic        Reset_n = 1'b0;
    logic        IoWrEn = 1'b0;
    logic [7:0]  IoWrData = '0;
    logic        IoRdEn = 1'b0;
    logic [3:0]  IoAddr = '0;
    logic [31:0] IoRdData;
    logic [7:0]  TxDataIn;
    logic        TxDataInValid;
    logic        TxDataInReady = 1'b0;
    logic [7:0]  RxDataOut = '0;
    logic        RxDataOutValid = 1'b0;
    logic        RxDataOutReady;

    int checks = 0;
    int failures = 0;

    logic [7:0] exp_tx[$];
    logic [7:0] rxq[$];
    logic       m_ovr = 1'b0;
    logic       m_ovf = 1'b0;

    uart_io_ctrl #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
        .Clock          (Clock),
        .Reset_n        (Reset_n),
        .IoWrEn         (IoWrEn),
        .IoWrData       (IoWrData),
        .IoRdEn         (IoRdEn),
        .IoAddr         (IoAddr),
        .IoRdData       (IoRdData),
        .TxDataIn       (TxDataIn),
        .TxDataInValid  (TxDataInValid),
        .TxDataInReady  (TxDataInReady),
        .RxDataOut      (RxDataOut),
        .RxDataOutValid (RxDataOutValid),
        .RxDataOutReady (RxDataOutReady)
    );

    always #5 Clock = ~Clock;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Entered shortly after a rising edge; samples at the falling edge,
    // then advances the model past the next rising edge.
    task automatic cyc(input logic wr, input logic [7:0] wd,
                       input logic rd, input logic [3:0] addr,
                       input logic rxv, input logic [7:0] rxd,
                       input logic txr, input logic drop,
                       output logic [31:0] rdv, output logic vld,
                       output logic rdy);
        logic hs;
        logic rx_acc;
        logic rx_pop;
        logic clr;
        IoWrEn = wr;
        IoWrData = wd;
        IoRdEn = rd;
        IoAddr = addr;
        RxDataOutValid = rxv;
        RxDataOut = rxd;
        TxDataInReady = txr;
        @(negedge Clock);
        rdv = IoRdData;
        vld = TxDataInValid;
        rdy = RxDataOutReady;
        chk("rx_ready", 32'(rdy), 32'(rxq.size() < RXD));
        if (vld) begin
            if (exp_tx.size() == 0) chk("tx_spurious", 32'(vld), 32'd0);
            else chk("tx_data", 32'(TxDataIn), 32'(exp_tx[0]));
        end
        hs = vld && txr;
        rx_acc = rxv && (rxq.size() < RXD);
        rx_pop = rd && (addr == 4'hC) && (rxq.size() != 0);
        clr = rd && (addr == 4'h8);
        if (rd) begin
            case (addr)
                4'h0: if (exp_tx.size() < TXD) chk("rd_tx_rdy", rdv, 32'd1);
                4'h4: chk("rd_rx_vld", rdv, 32'(rxq.size() != 0));
                4'h8: chk("rd_status", rdv & 32'hFFFF_FF03,
                          {16'b0, 8'(rxq.size()), 6'b0, m_ovr, m_ovf});
                4'hC: chk("rd_rx_data", rdv,
                          (rxq.size() != 0) ? {24'b0, rxq[0]} : 32'd0);
                default: chk("rd_other", rdv, 32'd0);
            endcase
        end
        @(posedge Clock);
        #1;
        if (hs && exp_tx.size() != 0) void'(exp_tx.pop_front());
        if (wr && !drop) exp_tx.push_back(wd);
        if (rx_pop) void'(rxq.pop_front());
        if (rx_acc) rxq.push_back(rxd);
        m_ovr = (rxv && !rx_acc) || (m_ovr && !clr);
        m_ovf = (wr && drop) || (m_ovf && !clr);
        IoWrEn = 1'b0;
        IoRdEn = 1'b0;
        RxDataOutValid = 1'b0;
    endtask

    task automatic lb_step(input logic wr, input logic [7:0] wd,
                           input logic rd, input logic [3:0] addr,
                           output logic [31:0] rdv);
        IoWrEn = wr;
        IoWrData = wd;
        IoRdEn = rd;
        IoAddr = addr;
        RxDataOutValid = 1'b1;
        RxDataOut = 8'hFF;
        TxDataInReady = 1'b1;
        @(negedge Clock);
        rdv = IoRdData;
        chk("lb_tx_valid", 32'(TxDataInValid), 32'd0);
        chk("lb_rx_ready", 32'(RxDataOutReady), 32'd0);
        @(posedge Clock);
        #1;
        IoWrEn = 1'b0;
        IoRdEn = 1'b0;
    endtask

    initial begin
        logic [31:0] rdv;
        logic        vld;
        logic        rdy;
        repeat (3) @(posedge Clock);
        #1 Reset_n = 1'b1;
        #1;
        chk("rst_tx_valid", 32'(TxDataInValid), 32'd0);
        chk("rst_tx_data", 32'(TxDataIn), 32'd0);
`ifdef UART_IO_LOOPBACK_EN
        chk("rst_rx_ready", 32'(RxDataOutReady), 32'd0);
        lb_step(1'b1, 8'h12, 1'b0, 4'h0, rdv);
        lb_step(1'b1, 8'h34, 1'b0, 4'h0, rdv);
        for (int i = 0; i < 4; i++) lb_step(1'b0, 8'h00, 1'b0, 4'h0, rdv);
        lb_step(1'b0, 8'h00, 1'b1, 4'h4, rdv);
        chk("lb_rx_vld", rdv, 32'd1);
        lb_step(1'b0, 8'h00, 1'b1, 4'hC, rdv);
        chk("lb_byte0", rdv, 32'h12);
        lb_step(1'b0, 8'h00, 1'b1, 4'hC, rdv);
        chk("lb_byte1", rdv, 32'h34);
        lb_step(1'b0, 8'h00, 1'b1, 4'h4, rdv);
        chk("lb_rx_empty", rdv, 32'd0);
`else
        chk("rst_rx_ready", 32'(RxDataOutReady), 32'd1);
        cyc(0, 0, 1, 4'h0, 0, 0, 0, 0, rdv, vld, rdy);
        chk("rst_rd0", rdv, 32'd1);
        cyc(0, 0, 1, 4'h4, 0, 0, 0, 0, rdv, vld, rdy);
        chk("rst_rd4", rdv, 32'd0);
        cyc(0, 0, 1, 4'h8, 0, 0, 0, 0, rdv, vld, rdy);
        chk("rst_rd8", rdv, 32'd0);

        cyc(1, 8'h41, 0, 0, 0, 0, 1, 0, rdv, vld, rdy);
        chk("st_vld_edge", 32'(vld), 32'd0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, rdv, vld, rdy);
        chk("st_vld_n", 32'(vld), 32'd0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, rdv, vld, rdy);
        chk("st_vld_n1", 32'(vld), 32'd1);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, rdv, vld, rdy);
        chk("st_vld_n2", 32'(vld), 32'd0);

        for (int i = 0; i < TXD + 1; i++)
            cyc(1, 8'(8'h60 + i), 0, 0, 0, 0, 0, 0, rdv, vld, rdy);
        cyc(0, 0, 1, 4'h0, 0, 0, 0, 0, rdv, vld, rdy);
        chk("ovf_full_rdy", rdv, 32'd0);
        cyc(0, 0, 1, 4'h8, 0, 0, 0, 0, rdv, vld, rdy);
        chk("ovf_none", rdv, 32'h20);
        cyc(1, 8'hEE, 0, 0, 0, 0, 0, 1, rdv, vld, rdy);
        cyc(0, 0, 1, 4'h8, 0, 0, 0, 0, rdv, vld, rdy);
        chk("ovf_set", rdv, 32'h21);
        cyc(0, 0, 1, 4'h8, 0, 0, 0, 0, rdv, vld, rdy);
        chk("ovf_clear", rdv, 32'h20);
        for (int i = 0; i < TXD + 1; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 1, 0, rdv, vld, rdy);
            chk("drain_b2b", 32'(vld), 32'd1);
        end
        cyc(0, 0, 0, 0, 0, 0, 1, 0, rdv, vld, rdy);
        chk("drain_done", 32'(vld), 32'd0);
        chk("drain_count", 32'(exp_tx.size()), 32'd0);

        cyc(0, 0, 0, 0, 1, 8'h55, 0, 0, rdv, vld, rdy);
        cyc(0, 0, 0, 0, 1, 8'hAA, 0, 0, rdv, vld, rdy);
        cyc(0, 0, 1, 4'h4, 0, 0, 0, 0, rdv, vld, rdy);
        chk("rx_vld", rdv, 32'd1);
        cyc(0, 0, 1, 4'hC, 0, 0, 0, 0, rdv, vld, rdy);
        chk("rx_first", rdv, 32'h55);
        cyc(0, 0, 1, 4'hC, 0, 0, 0, 0, rdv, vld, rdy);
        chk("rx_second", rdv, 32'hAA);
        cyc(0, 0, 1, 4'hC, 0, 0, 0, 0, rdv, vld, rdy);
        chk("rx_pop_empty", rdv, 32'd0);
        cyc(0, 0, 1, 4'h4, 0, 0, 0, 0, rdv, vld, rdy);
        chk("rx_vld_empty", rdv, 32'd0);

        for (int i = 0; i < RXD; i++)
            cyc(0, 0, 0, 0, 1, 8'($urandom), 0, 0, rdv, vld, rdy);
        cyc(0, 0, 0, 0, 1, 8'hC3, 0, 0, rdv, vld, rdy);
        chk("rx_full_rdy", 32'(rdy), 32'd0);
        cyc(0, 0, 1, 4'h8, 0, 0, 0, 0, rdv, vld, rdy);
        chk("rx_overrun", rdv, 32'h0802);
        cyc(0, 0, 1, 4'hC, 1, 8'h3C, 0, 0, rdv, vld, rdy);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, rdv, vld, rdy);
        chk("rx_rdy_back", 32'(rdy), 32'd1);

        cyc(1, 8'h77, 0, 0, 0, 0, 0, 0, rdv, vld, rdy);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, rdv, vld, rdy);
        chk("mid_vld_pre", 32'(TxDataInValid), 32'd1);
        Reset_n = 1'b0;
        #1;
        chk("mid_vld_drop", 32'(TxDataInValid), 32'd0);
        chk("mid_data_clr", 32'(TxDataIn), 32'd0);
        exp_tx.delete();
        rxq.delete();
        m_ovr = 1'b0;
        m_ovf = 1'b0;
        @(posedge Clock);
        #1 Reset_n = 1'b1;
        #1;
        cyc(0, 0, 1, 4'h4, 0, 0, 0, 0, rdv, vld, rdy);
        chk("mid_rx_gone", rdv, 32'd0);

        for (int i = 0; i < 400; i++) begin
            logic [3:0] a;
            int         sel;
            sel = int'($urandom_range(0, 4));
            a = (sel == 0) ? 4'h0 : (sel == 1) ? 4'h4 :
                (sel == 2) ? 4'h8 : (sel == 3) ? 4'hC : 4'h6;
            cyc(1'(($urandom % 3) == 0) && (exp_tx.size() < TXD),
                8'($urandom), 1'($urandom % 2), a,
                1'($urandom % 2), 8'($urandom),
                1'(($urandom % 4) != 0), 1'b0, rdv, vld, rdy);
        end
        for (int i = 0; i < 40 && exp_tx.size() != 0; i++)
            cyc(0, 0, 0, 0, 0, 0, 1, 0, rdv, vld, rdy);
        chk("final_drain", 32'(exp_tx.size()), 32'd0);
        for (int i = 0; i < RXD + 1; i++)
            cyc(0, 0, 1, 4'hC, 0, 0, 0, 0, rdv, vld, rdy);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
